// File: rtl/rs_bm_iter.sv
// Berlekamp-Massey error-locator solver for Reed-Solomon decoding.
// It accepts one syndrome word and runs UNROLL BM iterations per clock.
// Results are presented as Lambda (constant term at index 0), the LFSR
// length L, and a fail flag that is set when L exceeds T_VAL.
module rs_bm_iter #(
    parameter int SYMB_WIDTH = 8,
    parameter int ROOTS_NUM  = 16,
    parameter int UNROLL     = 1,
    // Low bits of the field's primitive polynomial; the x^m term is implied (0x11D -> 0x1D).
    parameter logic [SYMB_WIDTH-1:0] POLY_LOW = 'h1D,
    localparam int T_VAL = ROOTS_NUM / 2,
    localparam int LEN_W = $clog2(ROOTS_NUM + 1)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [ROOTS_NUM*SYMB_WIDTH-1:0]   syndrome,
    input  logic                              syndrome_vld,
    output logic                              syndrome_rdy,
    output logic [(T_VAL+1)*SYMB_WIDTH-1:0]   error_locator_out,
    output logic [LEN_W-1:0]                  error_locator_len,
    output logic                              decode_fail,
    output logic                              error_locator_vld,
    input  logic                              error_locator_rdy
);

    localparam int OUT_W = (T_VAL + 1) * SYMB_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [SYMB_WIDTH-1:0] sym_t;

    if ((ROOTS_NUM % UNROLL) != 0) begin : g_bad_unroll
        $error("rs_bm_iter: UNROLL must divide ROOTS_NUM");
    end

    // GF(2^m) multiply: shift-and-add with reduction by the primitive polynomial.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ POLY_LOW) : (sh << 1);
        end
        return acc;
    endfunction

    // GF(2^m) inverse as a^(2^m - 2), built from repeated squaring.
    function automatic sym_t gf_inv(input sym_t a);
        sym_t t;
        sym_t acc;
        t   = a;
        acc = sym_t'(1);
        for (int i = 1; i < SYMB_WIDTH; i++) begin
            t   = gf_mul(t, t);
            acc = gf_mul(acc, t);
        end
        return acc;
    endfunction

    state_t           state;
    logic             rdy_q;
    logic             vld_q;
    logic             fail_q;
    logic [LEN_W-1:0] len_q;
    logic [OUT_W-1:0] out_q;
    logic [LEN_W-1:0] r_q;
    logic [LEN_W-1:0] l_q;
    sym_t             syn_q [ROOTS_NUM];
    sym_t             lam_q [ROOTS_NUM+1];
    sym_t             b_q   [ROOTS_NUM+1];

    sym_t             lam_c [ROOTS_NUM+1];
    sym_t             lam_n [ROOTS_NUM+1];
    sym_t             b_c   [ROOTS_NUM+1];
    sym_t             xb    [ROOTS_NUM+1];
    logic [LEN_W-1:0] l_c;
    logic [LEN_W:0]   rr;
    sym_t             delta;
    sym_t             dinv;
    sym_t             s_sel;

    assign syndrome_rdy      = rdy_q;
    assign error_locator_vld = vld_q;
    assign error_locator_out = out_q;
    assign error_locator_len = len_q;
    assign decode_fail       = fail_q;

    // UNROLL chained BM iterations starting at iteration r_q.
    always_comb begin
        lam_c = lam_q;
        lam_n = lam_q;
        b_c   = b_q;
        xb    = b_q;
        l_c   = l_q;
        rr    = '0;
        delta = '0;
        dinv  = '0;
        s_sel = '0;
        for (int u = 0; u < UNROLL; u++) begin
            rr    = (LEN_W+1)'(r_q) + (LEN_W+1)'(u);
            delta = '0;
            for (int j = 0; j < ROOTS_NUM; j++) begin
                // S(r-j); stays zero when r-j is negative.
                s_sel = '0;
                for (int k = 0; k < ROOTS_NUM; k++) begin
                    if ((LEN_W+1)'(j + k) == rr) s_sel = syn_q[k];
                end
                if (LEN_W'(j) <= l_c) delta = delta ^ gf_mul(lam_c[j], s_sel);
            end
            xb[0] = '0;
            for (int i = 1; i <= ROOTS_NUM; i++) xb[i] = b_c[i-1];
            if (delta != '0) begin
                dinv = gf_inv(delta);
                for (int i = 0; i <= ROOTS_NUM; i++) lam_n[i] = lam_c[i] ^ gf_mul(delta, xb[i]);
                // Extra bit on both sides keeps 2L <= r from wrapping.
                if ({l_c, 1'b0} <= rr) begin
                    for (int i = 0; i <= ROOTS_NUM; i++) b_c[i] = gf_mul(dinv, lam_c[i]);
                    l_c = LEN_W'(rr + 1'b1 - {1'b0, l_c});
                end else begin
                    b_c = xb;
                end
                lam_c = lam_n;
            end else begin
                b_c = xb;
            end
        end
    end

    // Control FSM plus the working and result registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            fail_q <= 1'b0;
            len_q  <= '0;
            out_q  <= OUT_W'(1);
            r_q    <= '0;
            l_q    <= '0;
            for (int i = 0; i < ROOTS_NUM; i++) syn_q[i] <= '0;
            for (int i = 0; i <= ROOTS_NUM; i++) begin
                lam_q[i] <= (i == 0) ? sym_t'(1) : '0;
                b_q[i]   <= (i == 0) ? sym_t'(1) : '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (syndrome_vld) begin
                        for (int i = 0; i < ROOTS_NUM; i++) syn_q[i] <= syndrome[i*SYMB_WIDTH +: SYMB_WIDTH];
                        for (int i = 0; i <= ROOTS_NUM; i++) begin
                            lam_q[i] <= (i == 0) ? sym_t'(1) : '0;
                            b_q[i]   <= (i == 0) ? sym_t'(1) : '0;
                        end
                        r_q   <= '0;
                        l_q   <= '0;
                        rdy_q <= 1'b0;
                        // An all-zero word has no errors: Lambda = 1 is already the answer.
                        state <= (syndrome == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    lam_q <= lam_c;
                    b_q   <= b_c;
                    l_q   <= l_c;
                    r_q   <= r_q + LEN_W'(UNROLL);
                    if (r_q + LEN_W'(UNROLL) == LEN_W'(ROOTS_NUM)) state <= DONE;
                end
                DONE: begin
                    if (!vld_q) begin
                        for (int i = 0; i <= T_VAL; i++) out_q[i*SYMB_WIDTH +: SYMB_WIDTH] <= lam_q[i];
                        len_q  <= l_q;
                        fail_q <= (l_q > LEN_W'(T_VAL));
                        vld_q  <= 1'b1;
                    end else if (error_locator_rdy) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_bm_iter.sv
// Bench for rs_bm_iter: two instances (UNROLL=1 and UNROLL=4) share one
// stimulus stream and are compared against a table-based GF(2^8) Massey model.
module tb_rs_bm_iter;

    localparam int W  = 8;
    localparam int N  = 16;
    localparam int T  = 8;
    localparam int LW = 5;
    localparam int OW = (T + 1) * W;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N*W-1:0]  syndrome;
    logic            syndrome_vld;
    logic            error_locator_rdy;

    logic            s_rdy1, vld1, fail1;
    logic [OW-1:0]   out1;
    logic [LW-1:0]   len1;
    logic            s_rdy4, vld4, fail4;
    logic [OW-1:0]   out4;
    logic [LW-1:0]   len4;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    rs_bm_iter #(.SYMB_WIDTH(W), .ROOTS_NUM(N), .UNROLL(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .syndrome(syndrome), .syndrome_vld(syndrome_vld),
        .syndrome_rdy(s_rdy1), .error_locator_out(out1), .error_locator_len(len1),
        .decode_fail(fail1), .error_locator_vld(vld1), .error_locator_rdy(error_locator_rdy)
    );

    rs_bm_iter #(.SYMB_WIDTH(W), .ROOTS_NUM(N), .UNROLL(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .syndrome(syndrome), .syndrome_vld(syndrome_vld),
        .syndrome_rdy(s_rdy4), .error_locator_out(out4), .error_locator_len(len4),
        .decode_fail(fail4), .error_locator_vld(vld4), .error_locator_rdy(error_locator_rdy)
    );

    // GF(2^8) log/antilog tables over 0x11D
    int gexp [0:511];
    int glog [0:255];

    // model state
    int syn_m   [N];
    int xs      [16];
    int ys      [16];
    int exp_lam [64];
    int exp_l;
    int prod    [64];

    // valid-rise counters, sampled on the falling edge
    int   rise1 = 0, rise4 = 0;
    logic pv1 = 1'b0, pv4 = 1'b0;
    always @(negedge aclk) begin
        if (vld1 && !pv1) rise1++;
        if (vld4 && !pv4) rise4++;
        pv1 = vld1;
        pv4 = vld4;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i]       = x;
            gexp[i + 255] = x;
            glog[x]       = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        gexp[510] = gexp[0];
        gexp[511] = gexp[1];
        glog[0]   = 0;
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    function automatic int ginv(input int a);
        return gexp[255 - glog[a]];
    endfunction

    function automatic int gpow(input int a, input int e);
        return gexp[(glog[a] * e) % 255];
    endfunction

    // Textbook Massey recursion: C, B, L, gap m, last discrepancy b.
    task automatic bm_model();
        int c [64];
        int bb[64];
        int tt[64];
        int l, m, b, d, coef;
        for (int i = 0; i < 64; i++) begin c[i] = 0; bb[i] = 0; end
        c[0] = 1; bb[0] = 1; l = 0; m = 1; b = 1;
        for (int n = 0; n < N; n++) begin
            d = syn_m[n];
            for (int i = 1; i <= l; i++)
                if (n - i >= 0) d = d ^ gmul(c[i], syn_m[n - i]);
            if (d == 0) begin
                m++;
            end else begin
                coef = gmul(d, ginv(b));
                tt = c;
                for (int i = 0; i + m < 64; i++) c[i + m] = c[i + m] ^ gmul(coef, bb[i]);
                if (2 * l <= n) begin
                    l = n + 1 - l; bb = tt; b = d; m = 1;
                end else begin
                    m++;
                end
            end
        end
        exp_lam = c;
        exp_l   = l;
    endtask

    // Syndromes and the locator product prod(1 + X_k x) from xs/ys.
    task automatic make_syn(input int nerr);
        for (int i = 0; i < N; i++) begin
            syn_m[i] = 0;
            for (int k = 0; k < nerr; k++) syn_m[i] = syn_m[i] ^ gmul(ys[k], gpow(xs[k], i + 1));
        end
        for (int i = 0; i < 64; i++) prod[i] = 0;
        prod[0] = 1;
        for (int k = 0; k < nerr; k++)
            for (int i = 63; i >= 1; i--) prod[i] = prod[i] ^ gmul(xs[k], prod[i - 1]);
    endtask

    task automatic gen_random(input int nerr);
        int pos [16];
        bit dup;
        for (int k = 0; k < nerr; k++) begin
            do begin
                pos[k] = $urandom_range(0, 254);
                dup = 1'b0;
                for (int q = 0; q < k; q++) if (pos[q] == pos[k]) dup = 1'b1;
            end while (dup);
            xs[k] = gexp[pos[k]];
            ys[k] = $urandom_range(1, 255);
        end
        make_syn(nerr);
    endtask

    // Send syn_m to both instances, check latency and result, optionally
    // hold the result for hold_cyc cycles, then complete the handshake.
    task automatic run_vector(input int nerr, input bit use_prod, input int hold_cyc);
        logic [OW-1:0] exp_out, prod_out;
        logic [LW-1:0] exp_len;
        logic          exp_fail;
        bit            zero;
        int            lat1, lat4;
        bm_model();
        zero = 1'b1;
        for (int i = 0; i < N; i++) begin
            syndrome[i*W +: W] = W'(syn_m[i]);
            if (syn_m[i] != 0) zero = 1'b0;
        end
        for (int i = 0; i <= T; i++) begin
            exp_out[i*W +: W]  = W'(exp_lam[i]);
            prod_out[i*W +: W] = W'(prod[i]);
        end
        exp_len  = LW'(exp_l);
        exp_fail = (exp_l > T);

        check("syn_rdy1_idle", s_rdy1, 1'b1);
        check("syn_rdy4_idle", s_rdy4, 1'b1);
        syndrome_vld = 1'b1;
        tick();
        syndrome_vld = 1'b0;
        check("syn_rdy1_taken", s_rdy1, 1'b0);
        check("syn_rdy4_taken", s_rdy4, 1'b0);

        lat1 = -1; lat4 = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (vld1 && lat1 < 0) lat1 = c;
            if (vld4 && lat4 < 0) lat4 = c;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        check("latency1", lat1, zero ? 1 : N + 1);
        check("latency4", lat4, zero ? 1 : N / 4 + 1);
        check("lambda1", out1, exp_out);
        check("lambda4", out4, exp_out);
        check("len1", len1, exp_len);
        check("len4", len4, exp_len);
        check("fail1", fail1, exp_fail);
        check("fail4", fail4, exp_fail);
        if (use_prod) begin
            check("lambda1_prod", out1, prod_out);
            check("len1_nerr", len1, LW'(nerr));
        end

        for (int h = 0; h < hold_cyc; h++) begin
            syndrome_vld = h[0];
            syndrome     = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            check("hold_syn_rdy1", s_rdy1, 1'b0);
            check("hold_syn_rdy4", s_rdy4, 1'b0);
            check("hold_vld1", vld1, 1'b1);
            check("hold_lambda1", out1, exp_out);
            check("hold_lambda4", out4, exp_out);
            check("hold_len1", len1, exp_len);
        end
        syndrome_vld = 1'b0;

        error_locator_rdy = 1'b1;
        tick();
        error_locator_rdy = 1'b0;
        check("vld1_cleared", vld1, 1'b0);
        check("vld4_cleared", vld4, 1'b0);
        check("syn_rdy1_back", s_rdy1, 1'b1);
        check("syn_rdy4_back", s_rdy4, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld1"}, vld1, 1'b0);
        check({tag, "_vld4"}, vld4, 1'b0);
        check({tag, "_rdy1"}, s_rdy1, 1'b1);
        check({tag, "_rdy4"}, s_rdy4, 1'b1);
        check({tag, "_fail1"}, fail1, 1'b0);
        check({tag, "_len1"}, len1, 0);
        check({tag, "_out1"}, out1, 1);
        check({tag, "_out4"}, out4, 1);
    endtask

    initial begin
        int nerr, snap1, snap4;
        build_tables();
        aresetn           = 1'b0;
        syndrome          = '0;
        syndrome_vld      = 1'b0;
        error_locator_rdy = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick();

        // all-zero syndrome
        make_syn(0);
        run_vector(0, 1'b1, 0);

        // single error X=0x08, Y=0x05
        xs[0] = 'h08; ys[0] = 'h05;
        make_syn(1);
        run_vector(1, 1'b1, 0);
        check("single_lambda_const", out1, 72'h0801);

        // mixed random error counts 0..9
        for (int v = 0; v < 500; v++) begin
            nerr = $urandom_range(0, 9);
            gen_random(nerr);
            run_vector(nerr, nerr <= T, 0);
        end

        // exactly T errors, then T+1
        for (int v = 0; v < 30; v++) begin
            gen_random(8);
            run_vector(8, 1'b1, 0);
        end
        for (int v = 0; v < 30; v++) begin
            gen_random(9);
            run_vector(9, 1'b0, 0);
        end

        // result held in DONE for 20 cycles, then immediate next word
        gen_random(4);
        run_vector(4, 1'b1, 20);
        gen_random(2);
        run_vector(2, 1'b1, 0);

        // reset at RUN cycle 7 aborts the word
        gen_random(5);
        for (int i = 0; i < N; i++) syndrome[i*W +: W] = W'(syn_m[i]);
        syndrome_vld = 1'b1;
        tick();
        syndrome_vld = 1'b0;
        repeat (7) tick();
        snap1 = rise1;
        snap4 = rise4;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        aresetn = 1'b1;
        tick();
        check_reset_outputs("abort_rel");
        xs[0] = 'h08; ys[0] = 'h05;
        make_syn(1);
        run_vector(1, 1'b1, 0);
        repeat (4) tick();
        check("abort_rises1", rise1 - snap1, 1);
        check("abort_rises4", rise4 - snap4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
